// File: rtl/add_vector_sched.sv
// Vector adder front-end: streams N element pairs through one shared,
// pipelined scalar adder and reassembles the in-order results into c.
module add_vector_sched #(
  parameter int    BITS      = 16,
  parameter string PRECISION = "HALF",
  parameter int    N         = 3
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [BITS-1:0] a [N],
  input  logic [BITS-1:0] b [N],
  output logic            out_valid,
  output logic [BITS-1:0] c [N],
  output logic            add_in_valid,
  output logic [BITS-1:0] add_a,
  output logic [BITS-1:0] add_b,
  input  logic            add_out_valid,
  input  logic [BITS-1:0] add_c,
  output logic            err
);

  localparam int CW = $clog2(N + 1);
  localparam logic [CW-1:0] LAST = CW'(N - 1);
  localparam logic [CW-1:0] NUM  = CW'(N);

  typedef enum logic [1:0] {
    IDLE,
    ISSUE,
    DRAIN,
    DONE
  } state_e;

  state_e          state_q, state_d;
  logic [BITS-1:0] a_reg_q [N];
  logic [BITS-1:0] a_reg_d [N];
  logic [BITS-1:0] b_reg_q [N];
  logic [BITS-1:0] b_reg_d [N];
  logic [BITS-1:0] c_q [N];
  logic [BITS-1:0] c_d [N];
  logic [CW-1:0]   idx_q, idx_d;
  logic [CW-1:0]   ret_cnt_q, ret_cnt_d;
  logic            err_q, err_d;

  logic accept;
  logic ret_ok;
  logic ret_bad;
  logic last_ret;
  logic unused_prec;

  // Format tag is carried for documentation only.
  assign unused_prec = (PRECISION == "HALF");

  assign accept   = in_valid && in_ready;
  assign ret_ok   = add_out_valid
                 && (state_q == ISSUE || state_q == DRAIN)
                 && (ret_cnt_q != NUM);
  assign ret_bad  = add_out_valid && !ret_ok;
  assign last_ret = ret_ok && (ret_cnt_q == LAST);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE: begin
        if (accept) state_d = ISSUE;
      end
      ISSUE: begin
        // Early completion only if the adder returns faster than issue.
        if (last_ret)
          state_d = DONE;
        else if (idx_q == LAST)
          state_d = DRAIN;
      end
      DRAIN: begin
        if (last_ret) state_d = DONE;
      end
      DONE: begin
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    in_ready     = (state_q == IDLE) && !rst;
    out_valid    = (state_q == DONE);
    add_in_valid = (state_q == ISSUE);
    add_a        = '0;
    add_b        = '0;
    if (state_q == ISSUE) begin
      for (int i = 0; i < N; i++) begin
        if (idx_q == CW'(i)) begin
          add_a = a_reg_q[i];
          add_b = b_reg_q[i];
        end
      end
    end
  end

  always_comb begin
    a_reg_d   = a_reg_q;
    b_reg_d   = b_reg_q;
    c_d       = c_q;
    idx_d     = idx_q;
    ret_cnt_d = ret_cnt_q;
    err_d     = err_q || ret_bad;
    if (accept) begin
      a_reg_d   = a;
      b_reg_d   = b;
      idx_d     = '0;
      ret_cnt_d = '0;
    end
    if (state_q == ISSUE && idx_q != NUM) begin
      idx_d = idx_q + 1'b1;
    end
    if (ret_ok) begin
      for (int i = 0; i < N; i++) begin
        if (ret_cnt_q == CW'(i)) c_d[i] = add_c;
      end
      ret_cnt_d = ret_cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      a_reg_q   <= '{default: '0};
      b_reg_q   <= '{default: '0};
      c_q       <= '{default: '0};
      idx_q     <= '0;
      ret_cnt_q <= '0;
      err_q     <= 1'b0;
    end else begin
      a_reg_q   <= a_reg_d;
      b_reg_q   <= b_reg_d;
      c_q       <= c_d;
      idx_q     <= idx_d;
      ret_cnt_q <= ret_cnt_d;
      err_q     <= err_d;
    end
  end

  assign c   = c_q;
  assign err = err_q;

endmodule

// File: tb/tb_add_vector_sched.sv
// Bench for add_vector_sched: half-precision adder model with
// selectable latency and a queue of expected result vectors.
module tb_add_vector_sched;

  localparam int N = 3;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [15:0] a [N];
  logic [15:0] b [N];
  logic        out_valid;
  logic [15:0] c [N];
  logic        add_in_valid;
  logic [15:0] add_a, add_b;
  logic        add_out_valid;
  logic [15:0] add_c;
  logic        err;

  int          n_vec = 0;
  int          n_bad = 0;
  logic [47:0] exp_q [$];
  logic [47:0] last_c = '0;

  int          lat = 2;
  logic        spur = 1'b0;
  logic        pv0, pv1;
  logic [15:0] pd0, pd1;

  always #5 clk = ~clk;

  add_vector_sched #(
    .BITS(16),
    .PRECISION("HALF"),
    .N(N)
  ) dut (
    .clk(clk),
    .rst(rst),
    .in_valid(in_valid),
    .in_ready(in_ready),
    .a(a),
    .b(b),
    .out_valid(out_valid),
    .c(c),
    .add_in_valid(add_in_valid),
    .add_a(add_a),
    .add_b(add_b),
    .add_out_valid(add_out_valid),
    .add_c(add_c),
    .err(err)
  );

  // Positive normal half-precision add, truncating.
  function automatic logic [15:0] hadd(input logic [15:0] x, input logic [15:0] y);
    logic [4:0]  ex, ey, et;
    logic [11:0] mx, my, mt, s;
    ex = x[14:10];
    ey = y[14:10];
    mx = {2'b01, x[9:0]};
    my = {2'b01, y[9:0]};
    if (ey > ex) begin
      et = ex; ex = ey; ey = et;
      mt = mx; mx = my; my = mt;
    end
    my = my >> (ex - ey);
    s  = mx + my;
    if (s[11]) begin
      s  = s >> 1;
      ex = ex + 5'd1;
    end
    return {1'b0, ex, s[9:0]};
  endfunction

  function automatic logic [47:0] exp_of(input logic [47:0] av, input logic [47:0] bv);
    logic [47:0] r;
    for (int i = 0; i < N; i++) r[i*16 +: 16] = hadd(av[i*16 +: 16], bv[i*16 +: 16]);
    return r;
  endfunction

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      pv0 <= 1'b0; pv1 <= 1'b0;
      pd0 <= '0;   pd1 <= '0;
    end else begin
      pv0 <= add_in_valid;
      pd0 <= hadd(add_a, add_b);
      pv1 <= pv0;
      pd1 <= pd0;
    end
  end

  assign add_out_valid = spur | ((lat == 1) ? pv0 : pv1);
  assign add_c = spur ? 16'h1234 : ((lat == 1) ? pd0 : pd1);

  function automatic logic [47:0] got_c();
    return {c[2], c[1], c[0]};
  endfunction

  task automatic drive(input logic [47:0] av, input logic [47:0] bv);
    for (int i = 0; i < N; i++) begin
      a[i] = av[i*16 +: 16];
      b[i] = bv[i*16 +: 16];
    end
  endtask

  task automatic pop_exp(output logic [47:0] e);
    if (exp_q.size() > 0) e = exp_q.pop_front();
    else e = 'x;
    last_c = e;
  endtask

  // Returns in the cycle after acceptance (cycle t+1).
  task automatic send(input logic [47:0] av, input logic [47:0] bv, input bit keep);
    bit ok;
    drive(av, bv);
    in_valid = 1'b1;
    ok = 1'b0;
    for (int k = 0; k < 40; k++) begin
      if (in_ready) begin
        ok = 1'b1;
        break;
      end
      @(negedge clk);
    end
    n_vec++;
    if (!ok) begin
      n_bad++;
      $display("FAIL accept: in_ready=%b required 1", in_ready);
    end else begin
      exp_q.push_back(exp_of(av, bv));
    end
    @(negedge clk);
    if (!keep) in_valid = 1'b0;
  endtask

  task automatic wait_out(input int start, output int cyc);
    cyc = start;
    while (!out_valid && cyc < start + 40) begin
      @(negedge clk);
      cyc++;
    end
    if (!out_valid) cyc = -1;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    @(negedge clk);
    @(negedge clk);
    n_vec++;
    if ({in_ready, out_valid, add_in_valid, err} !== 4'b0) begin
      n_bad++;
      $display("FAIL reset_ctrl: got %b required 0000",
               {in_ready, out_valid, add_in_valid, err});
    end
    n_vec++;
    if ({got_c(), add_a, add_b} !== 80'h0) begin
      n_bad++;
      $display("FAIL reset_data: c=%h add_a=%h add_b=%h required 0", got_c(), add_a, add_b);
    end
    rst = 1'b0;
    #1;
    n_vec++;
    if (in_ready !== 1'b1) begin
      n_bad++;
      $display("FAIL reset_release_ready: got %b required 1", in_ready);
    end
  endtask

  task automatic test_basic();
    logic [47:0] av, bv, e, r;
    logic [33:0] obs, want;
    av = {16'h4200, 16'h4000, 16'h3C00};
    bv = {16'h3C00, 16'h3C00, 16'h3C00};
    send(av, bv, 1'b0);
    for (int cyc = 1; cyc <= 7; cyc++) begin
      obs = {add_in_valid, add_a, add_b, out_valid};
      if (cyc <= 3) want = {1'b1, av[(cyc-1)*16 +: 16], bv[(cyc-1)*16 +: 16], 1'b0};
      else want = {1'b0, 32'h0, cyc == 6};
      n_vec++;
      if (obs !== want) begin
        n_bad++;
        $display("FAIL basic_cycle%0d: got %h required %h", cyc, obs, want);
      end
      if (cyc == 6) begin
        pop_exp(e);
        r = got_c();
        n_vec++;
        if (r !== e || r !== {16'h4400, 16'h4200, 16'h4000}) begin
          n_bad++;
          $display("FAIL basic_c: got %h required %h", r, e);
        end
      end
      @(negedge clk);
    end
  endtask

  task automatic test_back_to_back();
    logic [47:0] v1a, v1b, v2a, v2b, e;
    int cyc;
    v1a = {16'h4400, 16'h4200, 16'h3800};
    v1b = {16'h4000, 16'h3C00, 16'h3800};
    v2a = {16'h4800, 16'h3C00, 16'h4500};
    v2b = {16'h4000, 16'h4400, 16'h3C00};
    send(v1a, v1b, 1'b1);
    drive(v2a, v2b);
    wait_out(1, cyc);
    n_vec++;
    if (cyc != 6) begin
      n_bad++;
      $display("FAIL b2b_first_latency: got %0d required 6", cyc);
    end
    pop_exp(e);
    n_vec++;
    if (got_c() !== e) begin
      n_bad++;
      $display("FAIL b2b_first_c: got %h required %h", got_c(), e);
    end
    n_vec++;
    if (in_ready !== 1'b0) begin
      n_bad++;
      $display("FAIL b2b_ready_in_done: got %b required 0", in_ready);
    end
    @(negedge clk);
    n_vec++;
    if (in_ready !== 1'b1) begin
      n_bad++;
      $display("FAIL b2b_ready_after: got %b required 1", in_ready);
    end
    exp_q.push_back(exp_of(v2a, v2b));
    @(negedge clk);
    in_valid = 1'b0;
    n_vec++;
    if ({add_in_valid, add_a} !== {1'b1, v2a[15:0]}) begin
      n_bad++;
      $display("FAIL b2b_second_issue: got %h required %h", {add_in_valid, add_a},
               {1'b1, v2a[15:0]});
    end
    wait_out(1, cyc);
    pop_exp(e);
    n_vec++;
    if (cyc != 6 || got_c() !== e) begin
      n_bad++;
      $display("FAIL b2b_second: cyc=%0d c=%h required cyc=6 c=%h", cyc, got_c(), e);
    end
    @(negedge clk);
  endtask

  task automatic test_lat1();
    logic [47:0] av, bv, e;
    int cyc;
    lat = 1;
    av = {16'h3C00, 16'h4600, 16'h4000};
    bv = {16'h4200, 16'h3C00, 16'h4000};
    send(av, bv, 1'b0);
    @(negedge clk);
    n_vec++;
    if ({add_in_valid, add_out_valid} !== 2'b11) begin
      n_bad++;
      $display("FAIL lat1_overlap: got %b required 11", {add_in_valid, add_out_valid});
    end
    wait_out(2, cyc);
    pop_exp(e);
    n_vec++;
    if (cyc != 5 || got_c() !== e) begin
      n_bad++;
      $display("FAIL lat1_done: cyc=%0d c=%h required cyc=5 c=%h", cyc, got_c(), e);
    end
    @(negedge clk);
    @(negedge clk);
    lat = 2;
  endtask

  task automatic test_change();
    logic [47:0] av, bv, e;
    int cyc;
    av = {16'h4100, 16'h3E00, 16'h4800};
    bv = {16'h3C00, 16'h4200, 16'h4400};
    send(av, bv, 1'b0);
    drive({3{16'h5000}}, {3{16'h5100}});
    in_valid = 1'b1;
    for (int k = 0; k < 3; k++) begin
      n_vec++;
      if ({add_a, add_b} !== {av[k*16 +: 16], bv[k*16 +: 16]}) begin
        n_bad++;
        $display("FAIL change_issue%0d: got %h required %h", k, {add_a, add_b},
                 {av[k*16 +: 16], bv[k*16 +: 16]});
      end
      @(negedge clk);
    end
    in_valid = 1'b0;
    wait_out(4, cyc);
    pop_exp(e);
    n_vec++;
    if (cyc != 6 || got_c() !== e) begin
      n_bad++;
      $display("FAIL change_c: cyc=%0d c=%h required cyc=6 c=%h", cyc, got_c(), e);
    end
    @(negedge clk);
  endtask

  task automatic test_midreset();
    logic [47:0] e;
    logic [49:0] obs;
    int cyc;
    send({16'h4000, 16'h4000, 16'h4000}, {16'h3C00, 16'h3C00, 16'h3C00}, 1'b0);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b1;
    #1;
    exp_q.delete();
    n_vec++;
    if ({in_ready, out_valid, add_in_valid, err, got_c()} !== 52'h0) begin
      n_bad++;
      $display("FAIL midreset_state: got %h required 0",
               {in_ready, out_valid, add_in_valid, err, got_c()});
    end
    @(negedge clk);
    rst = 1'b0;
    #1;
    n_vec++;
    if (in_ready !== 1'b1) begin
      n_bad++;
      $display("FAIL midreset_ready: got %b required 1", in_ready);
    end
    for (int k = 0; k < 6; k++) begin
      @(negedge clk);
      obs = {out_valid, err, got_c()};
      n_vec++;
      if (obs !== 50'h0) begin
        n_bad++;
        $display("FAIL midreset_quiet%0d: got %h required 0", k, obs);
      end
    end
    last_c = '0;
    send({16'h3C00, 16'h4400, 16'h4200}, {16'h3C00, 16'h3C00, 16'h4200}, 1'b0);
    wait_out(1, cyc);
    pop_exp(e);
    n_vec++;
    if (cyc != 6 || got_c() !== e) begin
      n_bad++;
      $display("FAIL midreset_fresh: cyc=%0d c=%h required cyc=6 c=%h", cyc, got_c(), e);
    end
    @(negedge clk);
  endtask

  task automatic test_spurious();
    logic [47:0] e;
    int cyc;
    n_vec++;
    if (err !== 1'b0) begin
      n_bad++;
      $display("FAIL spur_pre_err: got %b required 0", err);
    end
    spur = 1'b1;
    @(negedge clk);
    spur = 1'b0;
    n_vec++;
    if ({err, got_c()} !== {1'b1, last_c}) begin
      n_bad++;
      $display("FAIL spur_err_c: got %h required %h", {err, got_c()}, {1'b1, last_c});
    end
    @(negedge clk);
    @(negedge clk);
    n_vec++;
    if (err !== 1'b1) begin
      n_bad++;
      $display("FAIL spur_sticky: got %b required 1", err);
    end
    send({16'h4000, 16'h3C00, 16'h4400}, {16'h4000, 16'h4000, 16'h3C00}, 1'b0);
    wait_out(1, cyc);
    pop_exp(e);
    n_vec++;
    if (cyc != 6 || got_c() !== e || err !== 1'b1) begin
      n_bad++;
      $display("FAIL spur_after: cyc=%0d c=%h err=%b required cyc=6 c=%h err=1",
               cyc, got_c(), err, e);
    end
    @(negedge clk);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    drive('0, '0);
    test_reset();
    test_basic();
    test_back_to_back();
    test_lat1();
    test_change();
    test_midreset();
    test_spurious();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule

// File: doc/add_vector_sched.md
ADD_VECTOR_SCHED -- requirements
Module: add_vector_sched

Interface
REQ-001: The module SHALL have parameter BITS, default 16, meaning the element width.
REQ-002: The module SHALL have parameter PRECISION, default "HALF", meaning the format tag; it is informational only and is not decoded.
REQ-003: The module SHALL have parameter N, default 3, meaning the vector length; N >= 1.
REQ-004: The module SHALL have port clk, input, 1 bit: the single clock, rising-edge.
REQ-005: The module SHALL have port rst, input, 1 bit: asynchronous, active-high reset.
REQ-006: The module SHALL have port in_valid, input, 1 bit: request carries a vector pair.
REQ-007: The module SHALL have port in_ready, output, 1 bit: the block accepts a request this cycle.
REQ-008: The module SHALL have ports a[N] and b[N], input, BITS each: the operand vectors.
REQ-009: The module SHALL have port out_valid, output, 1 bit: a one-cycle pulse, c[N] is complete.
REQ-010: The module SHALL have port c[N], output, BITS each: the result vector, registered.
REQ-011: The module SHALL have port add_in_valid, output, 1 bit: issue strobe to the shared scalar adder.
REQ-012: The module SHALL have ports add_a and add_b, output, BITS each: the scalar adder operands.
REQ-013: The module SHALL have port add_out_valid, input, 1 bit: scalar adder result strobe.
REQ-014: The module SHALL have port add_c, input, BITS: the scalar adder result.
REQ-015: The module SHALL have port err, output, 1 bit: sticky protocol error flag.

Function
REQ-016: The block SHALL time-multiplex one external pipelined scalar adder, of fixed but unknown latency L >= 1 and in-order results, across the N elements.
REQ-017: The state machine SHALL have the states IDLE, ISSUE, DRAIN and DONE.
REQ-018: in_ready SHALL be 1 exactly when the state is IDLE and rst is 0.
REQ-019: In IDLE, when in_valid and in_ready are both 1, the block SHALL capture a and b into internal registers, clear the issue index and the return count, and go to ISSUE.
REQ-020: In ISSUE, the block SHALL drive add_in_valid=1, add_a=a_reg[idx] and add_b=b_reg[idx] for idx = 0..N-1 on consecutive cycles, with no bubbles.
REQ-021: After issuing idx = N-1, the block SHALL go to DRAIN; outside ISSUE, add_in_valid SHALL be 0 and add_a and add_b SHALL be 0.
REQ-022: In ISSUE or DRAIN, each cycle with add_out_valid=1 SHALL write add_c into c[ret_cnt] and increment ret_cnt; a return may arrive while still in ISSUE.
REQ-023: When the N-th return is captured, the block SHALL go to DONE on the next edge; this applies from DRAIN and also from ISSUE when L is small enough.
REQ-024: In DONE, out_valid SHALL be 1 for exactly one cycle, and the next state SHALL be IDLE.
REQ-025: Latency: with acceptance at edge t, issues SHALL occur in cycles t+1..t+N, the last return arrives at t+N+L, and out_valid SHALL be high in cycle t+N+L+1.
REQ-026: c SHALL hold its last value until it is overwritten element-by-element by the next request; the consumer samples c when out_valid=1.
REQ-027: An add_out_valid in IDLE or DONE, or with ret_cnt already equal to N, SHALL set err=1 and SHALL be ignored for c.
REQ-028: err SHALL be cleared only by rst.
REQ-029: in_valid in any state other than IDLE SHALL be ignored, and changes to a and b after acceptance SHALL NOT affect results.
REQ-030: idx and ret_cnt SHALL be sized $clog2(N+1) bits and SHALL never wrap within one request.

Reset
REQ-031: Asserting rst SHALL immediately force state=IDLE, in_ready=0, out_valid=0, add_in_valid=0, err=0, idx=0, ret_cnt=0, c[*]=0, a_reg[*]=0 and b_reg[*]=0.
REQ-032: Reset mid-operation SHALL abandon the vector in flight without asserting out_valid.
REQ-033: Adder returns arriving after reset release for a request abandoned by reset SHALL set err; the bench resets the adder model together with the block.
REQ-034: in_ready SHALL rise in the first cycle after rst deasserts.

Verification
REQ-035: Bench uses N=3, HALF, and an adder model with L=2. Scenario: a={0x3C00,0x4000,0x4200}, b={0x3C00,0x3C00,0x3C00} -> issues at t+1..t+3, out_valid at t+6, c={0x4000,0x4200,0x4400}.
REQ-036: Back-to-back: in_valid held high with two vectors -> second vector accepted in the cycle after the first out_valid, no overlap, both results correct.
REQ-037: With an L=1 model -> returns overlap ISSUE, and out_valid comes exactly 1 cycle after the third return.
REQ-038: Inject a spurious add_out_valid in IDLE -> err=1 and stays 1; c is unchanged; a subsequent normal vector completes correctly with err still 1.
REQ-039: Assert rst for one cycle after the second issue -> no out_valid, c={0,0,0}, in_ready=1 the cycle after release, and a fresh request completes normally.
REQ-040: Change a and b during ISSUE -> add_a and add_b still show the captured values, and c matches the captured operands.
